// File: rtl/exp_fsmd_param.sv
// Square-and-multiply exponentiation core: result = a^n, one exponent bit per clock (LSB first).
// Adds width parameters, early stop once the remaining exponent is zero, overflow flag, and saturate/wrap output.
module exp_fsmd_param #(
  parameter int A_W      = 8,
  parameter int N_W      = 8,
  parameter int R_W      = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go_i,
  input  logic [A_W-1:0] a_i,
  input  logic [N_W-1:0] n_i,
  output logic [R_W-1:0] output_reg,
  output logic           sig_done,
  output logic           busy_o,
  output logic           ovf_o
);

  // state | meaning
  // IDLE  | waiting for go_i after reset
  // CALC  | consuming one exponent bit per clock
  // DONE  | result valid on output_reg; go_i starts a new run
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [R_W-1:0] base_q, base_d;
  logic [R_W-1:0] res_q, res_d;
  logic [R_W-1:0] out_q, out_d;
  logic [N_W-1:0] e_q, e_d;
  logic           ovf_int_q, ovf_int_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           ovf_q, ovf_d;

  logic [2*R_W-1:0] prod_rb, prod_bb;
  logic [R_W-1:0]   res_nx;
  logic [N_W-1:0]   e_sh;
  logic             ovf_nx;

  always_comb begin
    prod_rb = {{R_W{1'b0}}, res_q} * {{R_W{1'b0}}, base_q};
    prod_bb = {{R_W{1'b0}}, base_q} * {{R_W{1'b0}}, base_q};
    e_sh    = e_q >> 1;
    res_nx  = e_q[0] ? prod_rb[R_W-1:0] : res_q;
    // a squaring that overflows is harmless when no exponent bits remain to use it
    ovf_nx  = ovf_int_q
            | (e_q[0] & (prod_rb[2*R_W-1:R_W] != '0))
            | ((prod_bb[2*R_W-1:R_W] != '0) & (e_sh != '0));
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    res_d     = res_q;
    out_d     = out_q;
    e_d       = e_q;
    ovf_int_d = ovf_int_q;
    done_d    = done_q;
    busy_d    = busy_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (go_i) begin
          base_d           = '0;
          base_d[A_W-1:0]  = a_i;
          e_d              = n_i;
          res_d            = {{(R_W-1){1'b0}}, 1'b1};
          ovf_int_d        = 1'b0;
          done_d           = 1'b0;
          busy_d           = 1'b1;
          state_d          = CALC;
        end
      end
      CALC: begin
        res_d     = res_nx;
        base_d    = prod_bb[R_W-1:0];
        e_d       = e_sh;
        ovf_int_d = ovf_nx;
        if (e_sh == '0) begin
          out_d   = (SATURATE && ovf_nx) ? '1 : res_nx;
          ovf_d   = ovf_nx;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      res_q     <= '0;
      out_q     <= '0;
      e_q       <= '0;
      ovf_int_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      res_q     <= res_d;
      out_q     <= out_d;
      e_q       <= e_d;
      ovf_int_q <= ovf_int_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign output_reg = out_q;
  assign sig_done   = done_q;
  assign busy_o     = busy_q;
  assign ovf_o      = ovf_q;

endmodule
